// File: rtl/register_block_pkg.sv
// Shared sizing constants and types for the per-core warp register file.
package register_block_pkg;

    localparam int unsigned NUM_LANES = 16;
    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned NUM_WARPS = 8;

    localparam int unsigned REG_AW = $clog2(NUM_REGS);
    localparam int unsigned WARP_W = $clog2(NUM_WARPS);

    // Words held by one lane: every register of every warp context.
    localparam int unsigned LANE_DEPTH = NUM_WARPS * NUM_REGS;
    localparam int unsigned LANE_AW    = WARP_W + REG_AW;

    typedef logic [DATA_W-1:0]    reg_data_t;
    typedef logic [REG_AW-1:0]    reg_addr_t;
    typedef logic [WARP_W-1:0]    warp_id_t;
    typedef logic [NUM_LANES-1:0] lane_mask_t;
    typedef logic [LANE_AW-1:0]   lane_index_t;

    // Flat word index inside one lane: warp context in the upper bits.
    function automatic lane_index_t lane_index(input warp_id_t warp, input reg_addr_t addr);
        return {warp, addr};
    endfunction

endpackage

// File: rtl/register_lane.sv
// One lane of the warp register file: all warps x all registers for a single lane,
// one write port and two enable-gated combinational read ports.
module register_lane
    import register_block_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  warp_id_t  warp,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_data_t wdata,
    input  logic      re_0,
    input  reg_addr_t raddr_0,
    input  logic      re_1,
    input  reg_addr_t raddr_1,
    output reg_data_t rdata_0,
    output reg_data_t rdata_1
);

    reg_data_t mem_q [LANE_DEPTH];

    // Storage update: synchronous clear of every word wins over a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LANE_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[lane_index(warp, waddr)] <= wdata;
        end
    end

    // Read ports see pre-edge contents; no bypass from the write port.
    always_comb begin
        rdata_0 = '0;
        rdata_1 = '0;
        if (re_0) rdata_0 = mem_q[lane_index(warp, raddr_0)];
        if (re_1) rdata_1 = mem_q[lane_index(warp, raddr_1)];
    end

endmodule

// File: rtl/warp_register_block.sv
// Per-core vector register file: 8 warps x 16 registers x 16 lanes x 64 bits.
// Fans shared address/warp buses out to one register_lane per lane and maps the
// flat per-lane data ports.
module warp_register_block
    import register_block_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  warp_id_t   warp_selector,
    input  lane_mask_t write_en,
    input  reg_addr_t  waddr,
    input  reg_data_t  wdata_0,
    input  reg_data_t  wdata_1,
    input  reg_data_t  wdata_2,
    input  reg_data_t  wdata_3,
    input  reg_data_t  wdata_4,
    input  reg_data_t  wdata_5,
    input  reg_data_t  wdata_6,
    input  reg_data_t  wdata_7,
    input  reg_data_t  wdata_8,
    input  reg_data_t  wdata_9,
    input  reg_data_t  wdata_10,
    input  reg_data_t  wdata_11,
    input  reg_data_t  wdata_12,
    input  reg_data_t  wdata_13,
    input  reg_data_t  wdata_14,
    input  reg_data_t  wdata_15,
    input  lane_mask_t read_en_0,
    input  reg_addr_t  raddr_0,
    input  lane_mask_t read_en_1,
    input  reg_addr_t  raddr_1,
    output reg_data_t  rdata_0_0,
    output reg_data_t  rdata_0_1,
    output reg_data_t  rdata_0_2,
    output reg_data_t  rdata_0_3,
    output reg_data_t  rdata_0_4,
    output reg_data_t  rdata_0_5,
    output reg_data_t  rdata_0_6,
    output reg_data_t  rdata_0_7,
    output reg_data_t  rdata_0_8,
    output reg_data_t  rdata_0_9,
    output reg_data_t  rdata_0_10,
    output reg_data_t  rdata_0_11,
    output reg_data_t  rdata_0_12,
    output reg_data_t  rdata_0_13,
    output reg_data_t  rdata_0_14,
    output reg_data_t  rdata_0_15,
    output reg_data_t  rdata_1_0,
    output reg_data_t  rdata_1_1,
    output reg_data_t  rdata_1_2,
    output reg_data_t  rdata_1_3,
    output reg_data_t  rdata_1_4,
    output reg_data_t  rdata_1_5,
    output reg_data_t  rdata_1_6,
    output reg_data_t  rdata_1_7,
    output reg_data_t  rdata_1_8,
    output reg_data_t  rdata_1_9,
    output reg_data_t  rdata_1_10,
    output reg_data_t  rdata_1_11,
    output reg_data_t  rdata_1_12,
    output reg_data_t  rdata_1_13,
    output reg_data_t  rdata_1_14,
    output reg_data_t  rdata_1_15
);

    reg_data_t wdata_arr   [NUM_LANES];
    reg_data_t rdata_0_arr [NUM_LANES];
    reg_data_t rdata_1_arr [NUM_LANES];

    assign wdata_arr[0]  = wdata_0;
    assign wdata_arr[1]  = wdata_1;
    assign wdata_arr[2]  = wdata_2;
    assign wdata_arr[3]  = wdata_3;
    assign wdata_arr[4]  = wdata_4;
    assign wdata_arr[5]  = wdata_5;
    assign wdata_arr[6]  = wdata_6;
    assign wdata_arr[7]  = wdata_7;
    assign wdata_arr[8]  = wdata_8;
    assign wdata_arr[9]  = wdata_9;
    assign wdata_arr[10] = wdata_10;
    assign wdata_arr[11] = wdata_11;
    assign wdata_arr[12] = wdata_12;
    assign wdata_arr[13] = wdata_13;
    assign wdata_arr[14] = wdata_14;
    assign wdata_arr[15] = wdata_15;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        register_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .warp    (warp_selector),
            .we      (write_en[l]),
            .waddr   (waddr),
            .wdata   (wdata_arr[l]),
            .re_0    (read_en_0[l]),
            .raddr_0 (raddr_0),
            .re_1    (read_en_1[l]),
            .raddr_1 (raddr_1),
            .rdata_0 (rdata_0_arr[l]),
            .rdata_1 (rdata_1_arr[l])
        );
    end

    assign rdata_0_0  = rdata_0_arr[0];
    assign rdata_0_1  = rdata_0_arr[1];
    assign rdata_0_2  = rdata_0_arr[2];
    assign rdata_0_3  = rdata_0_arr[3];
    assign rdata_0_4  = rdata_0_arr[4];
    assign rdata_0_5  = rdata_0_arr[5];
    assign rdata_0_6  = rdata_0_arr[6];
    assign rdata_0_7  = rdata_0_arr[7];
    assign rdata_0_8  = rdata_0_arr[8];
    assign rdata_0_9  = rdata_0_arr[9];
    assign rdata_0_10 = rdata_0_arr[10];
    assign rdata_0_11 = rdata_0_arr[11];
    assign rdata_0_12 = rdata_0_arr[12];
    assign rdata_0_13 = rdata_0_arr[13];
    assign rdata_0_14 = rdata_0_arr[14];
    assign rdata_0_15 = rdata_0_arr[15];

    assign rdata_1_0  = rdata_1_arr[0];
    assign rdata_1_1  = rdata_1_arr[1];
    assign rdata_1_2  = rdata_1_arr[2];
    assign rdata_1_3  = rdata_1_arr[3];
    assign rdata_1_4  = rdata_1_arr[4];
    assign rdata_1_5  = rdata_1_arr[5];
    assign rdata_1_6  = rdata_1_arr[6];
    assign rdata_1_7  = rdata_1_arr[7];
    assign rdata_1_8  = rdata_1_arr[8];
    assign rdata_1_9  = rdata_1_arr[9];
    assign rdata_1_10 = rdata_1_arr[10];
    assign rdata_1_11 = rdata_1_arr[11];
    assign rdata_1_12 = rdata_1_arr[12];
    assign rdata_1_13 = rdata_1_arr[13];
    assign rdata_1_14 = rdata_1_arr[14];
    assign rdata_1_15 = rdata_1_arr[15];

endmodule

// File: tb/tb_warp_register_block.sv
// Scoreboard bench for warp_register_block: stimulus queues expected read data,
// a negedge monitor pops and compares against the combinational read ports.
module tb_warp_register_block;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  warp_sel;
    logic [15:0] write_en;
    logic [3:0]  waddr;
    logic [63:0] wdata [16];
    logic [15:0] ren0, ren1;
    logic [3:0]  raddr0, raddr1;
    logic [63:0] rd0 [16];
    logic [63:0] rd1 [16];

    // Independent reference of the storage, updated when a write commits.
    logic [63:0] model [8][16][16];

    typedef struct {
        int          tid;
        bit          port;
        int          lane;
        logic [63:0] exp;
    } exp_t;

    exp_t sb [$];
    int n_applied = 0;
    int n_miscompare = 0;

    always #5 clk = ~clk;

    warp_register_block dut (
        .clk(clk), .rst_n(rst_n), .warp_selector(warp_sel), .write_en(write_en),
        .waddr(waddr),
        .wdata_0(wdata[0]),   .wdata_1(wdata[1]),   .wdata_2(wdata[2]),   .wdata_3(wdata[3]),
        .wdata_4(wdata[4]),   .wdata_5(wdata[5]),   .wdata_6(wdata[6]),   .wdata_7(wdata[7]),
        .wdata_8(wdata[8]),   .wdata_9(wdata[9]),   .wdata_10(wdata[10]), .wdata_11(wdata[11]),
        .wdata_12(wdata[12]), .wdata_13(wdata[13]), .wdata_14(wdata[14]), .wdata_15(wdata[15]),
        .read_en_0(ren0), .raddr_0(raddr0), .read_en_1(ren1), .raddr_1(raddr1),
        .rdata_0_0(rd0[0]),   .rdata_0_1(rd0[1]),   .rdata_0_2(rd0[2]),   .rdata_0_3(rd0[3]),
        .rdata_0_4(rd0[4]),   .rdata_0_5(rd0[5]),   .rdata_0_6(rd0[6]),   .rdata_0_7(rd0[7]),
        .rdata_0_8(rd0[8]),   .rdata_0_9(rd0[9]),   .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
        .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
        .rdata_1_0(rd1[0]),   .rdata_1_1(rd1[1]),   .rdata_1_2(rd1[2]),   .rdata_1_3(rd1[3]),
        .rdata_1_4(rd1[4]),   .rdata_1_5(rd1[5]),   .rdata_1_6(rd1[6]),   .rdata_1_7(rd1[7]),
        .rdata_1_8(rd1[8]),   .rdata_1_9(rd1[9]),   .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
        .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
    );

    // Monitor: compare every queued expectation against the live read ports.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] got;
            e = sb.pop_front();
            got = e.port ? rd1[e.lane] : rd0[e.lane];
            n_applied++;
            if (got !== e.exp) begin
                n_miscompare++;
                $display("FAIL test%0d port%0d lane%0d: got %h expected %h",
                         e.tid, e.port, e.lane, got, e.exp);
            end
        end
    end

    task automatic push_exp(input int tid, input bit port, input int lane,
                            input logic [63:0] v);
        exp_t e;
        e.tid = tid; e.port = port; e.lane = lane; e.exp = v;
        sb.push_back(e);
    endtask

    // Same constant expected on every lane of both ports.
    task automatic push_const(input int tid, input logic [63:0] v);
        for (int l = 0; l < 16; l++) begin
            push_exp(tid, 1'b0, l, v);
            push_exp(tid, 1'b1, l, v);
        end
    endtask

    // Expected read data derived from the reference store and current read inputs.
    task automatic push_model(input int tid);
        for (int l = 0; l < 16; l++) begin
            push_exp(tid, 1'b0, l, ren0[l] ? model[warp_sel][raddr0][l] : 64'h0);
            push_exp(tid, 1'b1, l, ren1[l] ? model[warp_sel][raddr1][l] : 64'h0);
        end
    endtask

    // Checks happen at the negedge (pre-edge state), then the write/reset commits.
    task automatic cycle();
        @(negedge clk);
        @(posedge clk);
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 16; r++)
                for (int l = 0; l < 16; l++) begin
                    if (!rst_n) model[w][r][l] = 64'h0;
                    else if (write_en[l] && w == int'(warp_sel) && r == int'(waddr))
                        model[w][r][l] = wdata[l];
                end
        #1;
    endtask

    task automatic set_wdata_all(input logic [63:0] v);
        for (int l = 0; l < 16; l++) wdata[l] = v;
    endtask

    task automatic write_all(input logic [2:0] w, input logic [3:0] a, input logic [63:0] v);
        warp_sel = w; waddr = a; write_en = 16'hFFFF; set_wdata_all(v);
        cycle();
        write_en = 16'h0;
    endtask

    initial begin
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 16; r++)
                for (int l = 0; l < 16; l++) model[w][r][l] = 64'h0;
        rst_n = 1'b0; warp_sel = '0; write_en = '0; waddr = '0; set_wdata_all(64'h0);
        ren0 = 16'hFFFF; ren1 = 16'hFFFF; raddr0 = '0; raddr1 = '0;

        // 1: reset clears every warp/register
        cycle();
        rst_n = 1'b1;
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 16; a++) begin
                warp_sel = 3'(w); raddr0 = 4'(a); raddr1 = 4'(15 - a);
                push_const(1, 64'h0);
                cycle();
            end

        // 2: full-lane write then read on both ports
        warp_sel = 3'd0; waddr = 4'd3; write_en = 16'hFFFF;
        for (int l = 0; l < 16; l++) wdata[l] = 64'hA5A5_0000_0000_0000 + 64'(l);
        cycle();
        write_en = 16'h0; raddr0 = 4'd3; raddr1 = 4'd3;
        for (int l = 0; l < 16; l++) begin
            push_exp(2, 1'b0, l, 64'hA5A5_0000_0000_0000 + 64'(l));
            push_exp(2, 1'b1, l, 64'hA5A5_0000_0000_0000 + 64'(l));
        end
        cycle();

        // 3: warp isolation
        write_all(3'd2, 4'd5, 64'h1111);
        write_all(3'd6, 4'd5, 64'h2222);
        raddr0 = 4'd5; raddr1 = 4'd5;
        warp_sel = 3'd2; push_const(3, 64'h1111); cycle();
        warp_sel = 3'd6; push_const(3, 64'h2222); cycle();
        warp_sel = 3'd0; push_const(3, 64'h0);    cycle();

        // 4: partial lane mask, then port-0 read gating
        warp_sel = 3'd0; waddr = 4'd3; write_en = 16'h00F0; set_wdata_all(64'hDEAD);
        cycle();
        write_en = 16'h0; raddr0 = 4'd3; raddr1 = 4'd3; ren0 = 16'h0;
        for (int l = 0; l < 16; l++) begin
            push_exp(4, 1'b0, l, 64'h0);
            push_exp(4, 1'b1, l, (l >= 4 && l <= 7) ? 64'hDEAD
                                                     : 64'hA5A5_0000_0000_0000 + 64'(l));
        end
        cycle();
        ren0 = 16'hFFFF;

        // 5: sweep of random full-lane writes, checking each port alone then both
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 16; a++)
                for (int k = 0; k < 10; k++) begin
                    warp_sel = 3'(w); waddr = 4'(a); write_en = 16'hFFFF;
                    for (int l = 0; l < 16; l++) wdata[l] = {$urandom, $urandom};
                    cycle();
                    write_en = 16'h0;
                    raddr0 = 4'(a); raddr1 = 4'(a);
                    ren0 = 16'hFFFF; ren1 = 16'h0;    push_model(5); cycle();
                    ren0 = 16'h0;    ren1 = 16'hFFFF; push_model(5); cycle();
                    ren0 = 16'hFFFF; raddr1 = 4'(15 - a); push_model(5); cycle();
                end

        // 6: same-cycle read of the register being written, then reset over a write
        write_all(3'd0, 4'd7, 64'h77);
        raddr0 = 4'd7; raddr1 = 4'd7; ren0 = 16'hFFFF; ren1 = 16'hFFFF;
        write_en = 16'hFFFF; set_wdata_all(64'h88);
        push_const(6, 64'h77);
        cycle();
        write_en = 16'h0;
        push_const(6, 64'h88);
        cycle();
        rst_n = 1'b0; write_en = 16'hFFFF; set_wdata_all(64'h99);
        push_const(6, 64'h88);
        cycle();
        rst_n = 1'b1; write_en = 16'h0;
        push_const(6, 64'h0);
        cycle();
        warp_sel = 3'd2; raddr0 = 4'd5; raddr1 = 4'd5;
        push_const(6, 64'h0);
        cycle();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_miscompare++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
